// File: rtl/ppc_types.sv
// Shared types for the integer arithmetic path: decoded control word, carry-in
// source encodings and a CR0 helper.
package ppc_types;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned GPR_ADDR_W = 5;

    typedef enum logic [1:0] {
        CarrySub    = 2'b00,  // carry-in follows subtract (two's-complement negate)
        CarryStored = 2'b01,
        CarryOne    = 2'b10,
        CarryZero   = 2'b11
    } carry_mode_e;

    typedef struct packed {
        logic        subtract;
        carry_mode_e carry_mode;
        logic        oe;
        logic        rc;
    } arith_ctrl_t;

    // {lt, gt, eq} of a signed value against zero
    function automatic logic [2:0] cr0_of(input logic [XLEN-1:0] value);
        return {value[XLEN-1], !value[XLEN-1] && (value != '0), value == '0};
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix over reservation-station entries and one-hot pick of the oldest
// ready entry.
module rs_age_select #(
    parameter int unsigned RS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [RS_DEPTH-1:0] alloc,
    input  logic [RS_DEPTH-1:0] busy,
    input  logic [RS_DEPTH-1:0] ready,
    output logic [RS_DEPTH-1:0] grant
);

    // age_q[j][i] set means entry j is older than entry i
    logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] age_d [RS_DEPTH];

    always_comb begin
        age_d = age_q;
        for (int k = 0; k < RS_DEPTH; k++) begin
            if (alloc[k]) begin
                age_d[k] = '0;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    age_d[j][k] = busy[j] && (j != k);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (ready[j] && age_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/arith_rs_unit.sv
// Add/subtract reservation station with multi-bus operand capture, oldest-ready
// issue and an elastic PIPE_STAGES-deep result pipeline.
module arith_rs_unit
    import ppc_types::*;
#(
    parameter int unsigned RS_OFFSET    = 0,
    parameter int unsigned RS_DEPTH     = 8,
    parameter int unsigned RS_ID_WIDTH  = 5,
    parameter int unsigned UPDATE_PORTS = 2,
    parameter int unsigned PIPE_STAGES  = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      input_valid,
    output logic                                      input_ready,
    input  logic [4:0]                                result_reg_addr_in,
    input  logic [31:0]                               op1,
    input  logic [31:0]                               op2,
    input  logic                                      op1_valid,
    input  logic                                      op2_valid,
    input  logic [RS_ID_WIDTH-1:0]                    op1_rs_id,
    input  logic [RS_ID_WIDTH-1:0]                    op2_rs_id,
    input  logic                                      carry_in,
    input  logic                                      carry_valid,
    input  logic [RS_ID_WIDTH-1:0]                    carry_rs_id,
    input  arith_ctrl_t                               control,
    output logic [RS_ID_WIDTH-1:0]                    id_taken,
    input  logic [UPDATE_PORTS-1:0]                   update_valid,
    input  logic [UPDATE_PORTS-1:0][RS_ID_WIDTH-1:0]  update_rs_id,
    input  logic [UPDATE_PORTS-1:0][31:0]             update_value,
    input  logic [UPDATE_PORTS-1:0]                   update_carry_valid,
    input  logic [UPDATE_PORTS-1:0][RS_ID_WIDTH-1:0]  update_carry_rs_id,
    input  logic [UPDATE_PORTS-1:0]                   update_carry,
    output logic                                      output_valid,
    input  logic                                      output_ready,
    output logic [RS_ID_WIDTH-1:0]                    rs_id_out,
    output logic [4:0]                                result_reg_addr_out,
    output logic [31:0]                               result,
    output logic                                      ca_out,
    output logic                                      ov_out,
    output logic [2:0]                                cr0_out
);

    localparam int unsigned IDX_W = $clog2(RS_DEPTH);
    localparam int unsigned LAST  = PIPE_STAGES - 1;

    typedef logic [RS_ID_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic                  busy;
        logic [XLEN-1:0]       op1;
        logic                  op1_v;
        tag_t                  op1_tag;
        logic [XLEN-1:0]       op2;
        logic                  op2_v;
        tag_t                  op2_tag;
        logic                  cy;
        logic                  cy_v;
        tag_t                  cy_tag;
        arith_ctrl_t           ctrl;
        logic [GPR_ADDR_W-1:0] dest;
    } entry_t;

    typedef struct packed {
        logic                  valid;
        tag_t                  rs_id;
        logic [GPR_ADDR_W-1:0] dest;
        logic [XLEN-1:0]       result;
        logic                  ca;
        logic                  ov;
        logic [2:0]            cr0;
    } stage_t;

    entry_t ent_q [RS_DEPTH];
    entry_t ent_d [RS_DEPTH];
    stage_t stg_q [PIPE_STAGES];
    stage_t stg_d [PIPE_STAGES];

    logic [RS_DEPTH-1:0]    busy, ready, alloc, grant;
    logic [IDX_W-1:0]       free_idx, issue_idx;
    logic                   take, issue;
    logic [PIPE_STAGES-1:0] stage_ready;
    entry_t                 new_ent, iss;
    stage_t                 iss_stage;
    logic [XLEN-1:0]        a_op;
    logic                   cin;
    logic [XLEN:0]          sum;

    always_comb begin
        free_idx  = '0;
        issue_idx = '0;
        for (int e = RS_DEPTH - 1; e >= 0; e--) begin
            busy[e]  = ent_q[e].busy;
            ready[e] = ent_q[e].busy && ent_q[e].op1_v && ent_q[e].op2_v && ent_q[e].cy_v;
            if (!ent_q[e].busy) free_idx = IDX_W'(e);
            if (grant[e])       issue_idx = IDX_W'(e);
        end
    end

    assign input_ready = ~&busy;
    assign take        = input_valid && input_ready && !flush;
    assign id_taken    = take ? tag_t'(RS_OFFSET) + tag_t'(free_idx) : '0;
    assign alloc       = take ? (RS_DEPTH'(1) << free_idx) : '0;
    assign issue       = (|grant) && stage_ready[0] && !flush;

    rs_age_select #(
        .RS_DEPTH(RS_DEPTH)
    ) u_age (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .alloc(alloc),
        .busy (busy),
        .ready(ready),
        .grant(grant)
    );

    // Ports are scanned high-to-low so the lowest matching port wins.
    always_comb begin
        new_ent = '{busy: 1'b1, op1: op1, op1_v: op1_valid, op1_tag: op1_rs_id,
                    op2: op2, op2_v: op2_valid, op2_tag: op2_rs_id,
                    cy: carry_in, cy_v: carry_valid, cy_tag: carry_rs_id,
                    ctrl: control, dest: result_reg_addr_in};
        for (int p = int'(UPDATE_PORTS) - 1; p >= 0; p--) begin
            if (!op1_valid && update_valid[p] && update_rs_id[p] == op1_rs_id) begin
                new_ent.op1   = update_value[p];
                new_ent.op1_v = 1'b1;
            end
            if (!op2_valid && update_valid[p] && update_rs_id[p] == op2_rs_id) begin
                new_ent.op2   = update_value[p];
                new_ent.op2_v = 1'b1;
            end
            if (!carry_valid && update_carry_valid[p] && update_carry_rs_id[p] == carry_rs_id) begin
                new_ent.cy   = update_carry[p];
                new_ent.cy_v = 1'b1;
            end
        end
    end

    always_comb begin
        ent_d = ent_q;
        for (int e = 0; e < RS_DEPTH; e++) begin
            for (int p = int'(UPDATE_PORTS) - 1; p >= 0; p--) begin
                if (ent_q[e].busy && !ent_q[e].op1_v && update_valid[p]
                    && update_rs_id[p] == ent_q[e].op1_tag) begin
                    ent_d[e].op1   = update_value[p];
                    ent_d[e].op1_v = 1'b1;
                end
                if (ent_q[e].busy && !ent_q[e].op2_v && update_valid[p]
                    && update_rs_id[p] == ent_q[e].op2_tag) begin
                    ent_d[e].op2   = update_value[p];
                    ent_d[e].op2_v = 1'b1;
                end
                if (ent_q[e].busy && !ent_q[e].cy_v && update_carry_valid[p]
                    && update_carry_rs_id[p] == ent_q[e].cy_tag) begin
                    ent_d[e].cy   = update_carry[p];
                    ent_d[e].cy_v = 1'b1;
                end
            end
        end
        if (issue) ent_d[issue_idx].busy = 1'b0;
        if (take)  ent_d[free_idx] = new_ent;
        if (flush) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                ent_d[e].busy  = 1'b0;
                ent_d[e].op1_v = 1'b0;
                ent_d[e].op2_v = 1'b0;
                ent_d[e].cy_v  = 1'b0;
            end
        end
    end

    always_comb begin
        iss  = ent_q[issue_idx];
        a_op = iss.ctrl.subtract ? ~iss.op1 : iss.op1;
        cin  = 1'b0;
        case (iss.ctrl.carry_mode)
            CarrySub:    cin = iss.ctrl.subtract;
            CarryStored: cin = iss.cy;
            CarryOne:    cin = 1'b1;
            default:     cin = 1'b0;
        endcase
        sum = {1'b0, a_op} + {1'b0, iss.op2} + {{XLEN{1'b0}}, cin};
        iss_stage.valid  = 1'b1;
        iss_stage.rs_id  = tag_t'(RS_OFFSET) + tag_t'(issue_idx);
        iss_stage.dest   = iss.dest;
        iss_stage.result = sum[XLEN-1:0];
        iss_stage.ca     = sum[XLEN];
        // carry into the sign bit XOR carry out of it
        iss_stage.ov     = iss.ctrl.oe && (a_op[XLEN-1] ^ iss.op2[XLEN-1] ^ sum[XLEN-1] ^ sum[XLEN]);
        iss_stage.cr0    = iss.ctrl.rc ? cr0_of(sum[XLEN-1:0]) : 3'b000;
    end

    always_comb begin
        stage_ready[LAST] = !stg_q[LAST].valid || output_ready;
        for (int i = int'(LAST) - 1; i >= 0; i--) begin
            stage_ready[i] = !stg_q[i].valid || stage_ready[i+1];
        end
    end

    always_comb begin
        stg_d = stg_q;
        if (stage_ready[0]) begin
            stg_d[0].valid = issue;
            if (issue) stg_d[0] = iss_stage;
        end
        for (int i = 1; i < PIPE_STAGES; i++) begin
            if (stage_ready[i]) begin
                stg_d[i].valid = stg_q[i-1].valid;
                if (stg_q[i-1].valid) stg_d[i] = stg_q[i-1];
            end
        end
        if (flush) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                stg_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                ent_q[e] <= '0;
            end
            for (int i = 0; i < PIPE_STAGES; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            ent_q <= ent_d;
            stg_q <= stg_d;
        end
    end

    assign output_valid        = stg_q[LAST].valid;
    assign rs_id_out           = stg_q[LAST].rs_id;
    assign result_reg_addr_out = stg_q[LAST].dest;
    assign result              = stg_q[LAST].result;
    assign ca_out              = stg_q[LAST].ca;
    assign ov_out              = stg_q[LAST].ov;
    assign cr0_out             = stg_q[LAST].cr0;

endmodule

// File: doc/arith_rs_unit.md
# arith_rs_unit

Parametrised successor to the single-bus add/sub wrapper. It holds RS_DEPTH in-flight integer add/subtract instructions in an internal reservation station and captures operands from UPDATE_PORTS result buses, including the same cycle an instruction is taken. It issues the oldest ready entry into a PIPE_STAGES-deep arithmetic pipeline with per-stage backpressure and supports a global flush. It sits between dispatch and the completion/CDB arbiter.

## Interface
- RS_OFFSET, 0, value added to entry index to form the global RS id
- RS_DEPTH, 8, entries (2..16)
- RS_ID_WIDTH, 5, tag width; RS_OFFSET+RS_DEPTH-1 must fit
- UPDATE_PORTS, 2, number of operand/carry update buses (1..4)
- PIPE_STAGES, 1, arithmetic pipeline registers (1..3)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all entries and pipeline contents
- input_valid / input_ready  in/out  1  take handshake
- result_reg_addr_in  in  5  destination GPR
- op1, op2  in  32 each  operand values; op1_valid, op2_valid  in  1; op1_rs_id, op2_rs_id  in  RS_ID_WIDTH  producer tags
- carry_in, carry_valid  in  1 each; carry_rs_id  in  RS_ID_WIDTH
- control  in  arith_ctrl_t  decoded operation
- id_taken  out  RS_ID_WIDTH  global id of entry allocated this cycle
- update_valid  in  UPDATE_PORTS  per-bus valid; update_rs_id  in  UPDATE_PORTS×RS_ID_WIDTH; update_value  in  UPDATE_PORTS×32
- update_carry_valid  in  UPDATE_PORTS; update_carry_rs_id  in  UPDATE_PORTS×RS_ID_WIDTH; update_carry  in  UPDATE_PORTS×1
- output_valid / output_ready  out/in  1  result handshake
- rs_id_out  out  RS_ID_WIDTH; result_reg_addr_out  out  5; result  out  32
- ca_out, ov_out  out  1 each; cr0_out  out  3  {lt, gt, eq}

## Operation
- Entry fields: busy, op1/op2/carry value, valid flag and tag per operand, control, destination.
- Take: input_ready = at least one non-busy entry at the start of the cycle (an entry freed by issue is not reusable in the same cycle). On input_valid&&input_ready, the lowest-index free entry is written; id_taken = RS_OFFSET+index, held valid only in the take cycle.
- Capture: every cycle, each busy entry with an invalid operand compares its tag against all update buses; on a match, value and valid are set. Take-cycle forwarding: an invalid incoming operand whose tag matches an update in the same cycle is written as valid. If several buses match, the lowest port index wins. GPR buses feed op1/op2 only; carry buses feed carry only.
- Age: an RS_DEPTH×RS_DEPTH age matrix, set on take (the new entry is younger than all busy entries). Issue picks the oldest busy entry with all three operands valid. The entry is freed when stage 1 accepts it.
- Arithmetic, 33-bit: a' = subtract ? ~op1 : op1; cin = carry_mode 00 → subtract, 01 → stored carry, 10 → 1, 11 → 0. sum = a' + op2 + cin. result = sum[31:0]; ca_out = bit 32; ov_out = carry into bit 31 XOR carry out, and 0 when !oe. cr0_out is the signed compare of result with 0, and 000 when !rc.
- Flush: all busy, valid flags and pipeline valids are cleared next edge. Flush overrides a simultaneous take, and no id is taken that cycle.

## Timing
- Reset (rst low, asynchronous): all entries free, age matrix zero, pipeline empty. Outputs: input_ready=1, output_valid=0, id_taken=0, rs_id_out=0, result_reg_addr_out=0, result=0, ca_out=ov_out=0, cr0_out=0.
- Take with all operands valid in cycle N: issue-eligible in N+1, output_valid in N+1+PIPE_STAGES at the earliest.
- Pipeline: stage_ready[i] = !valid[i] || stage_ready[i+1]; last stage ready = output_ready. Bubbles collapse. Output holds stable while output_valid && !output_ready.
- Full: input_ready=0 until the cycle after an issue. Empty, or nothing ready: no issue and no spurious output.
- An update whose tag matches no entry is ignored.

## Structure
- Package ppc_types gains arith_ctrl_t {subtract, carry_mode[2], oe, rc} and the carry_mode encodings.
- A natural sub-module is rs_age_select (age matrix plus oldest-ready one-hot pick), parametrised by RS_DEPTH. The arithmetic datapath stays inline.

## Test plan
- Reset then a single take: op1=5, op2=7, add, all valid, output_ready=1 → result=12 after 1+PIPE_STAGES cycles, ca=0, id_taken=RS_OFFSET.
- subf: op1=1, op2=0 (mode 00, rc=1) → result=0xFFFFFFFF, ca=0, cr0=100. Add with oe=1: 0x7FFFFFFF+1 → ov=1, cr0=100 when rc=1.
- Dependency: take A with op2 invalid (tag 9), then take B ready; bus 1 delivers tag 9 two cycles later → B output first, then A, with A using the forwarded value.
- Take-cycle forwarding: take with op1 tag 3 invalid while update port 0 has tag 3 = 0x10 in the same cycle → entry issues next cycle using 0x10.
- Fill all RS_DEPTH entries with output_ready=0 → input_ready=0; release output_ready → entries drain oldest-first, and input_ready=1 the cycle after the first issue.
- Flush with the RS half full and the pipeline full → output_valid=0 next cycle, all entries free, and no later outputs.
